i2s_tx_unit: RTL and testbench

//  Downstream of dsp_unit: takes each processed stereo sample pair (dsp_out/valid_out) into a
//  one-deep holding buffer and serialises it onto an I2S bus (sck_out/ws_out/sdo_out).

---
 rtl/i2s_tx_unit.sv | 138 +++++++++++++
 tb/tb_i2s_tx_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_unit.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_unit
// Description : One-deep stereo sample buffer feeding an I2S serialiser, with
//               per-frame sample request, underrun/overrun flags and clean stop.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_unit #(
    parameter int SCK_DIV   = 4,
    parameter int DATA_BITS = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      play_in,
    input  logic [1:0][DATA_BITS-1:0] audio_in,
    input  logic                      valid_in,
    output logic                      req_out,
    output logic                      sck_out,
    output logic                      ws_out,
    output logic                      sdo_out,
    output logic                      underrun_out,
    output logic                      overrun_out
);

    localparam int c_div_w = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
    localparam int c_bit_w = $clog2(2 * SLOT_BITS);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(SCK_DIV / 2);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(2 * SLOT_BITS - 1);
    localparam logic [c_bit_w-1:0] c_ws_first = c_bit_w'(SLOT_BITS - 1);
    localparam logic [c_bit_w-1:0] c_ws_last  = c_bit_w'(2 * SLOT_BITS - 2);
    localparam logic [c_bit_w-1:0] c_slot     = c_bit_w'(SLOT_BITS);
    localparam logic [c_bit_w-1:0] c_data     = c_bit_w'(DATA_BITS);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_run      = 2'd1;
    localparam logic [1:0] c_stopping = 2'd2;

    logic [1:0]                r_state;
    logic [c_div_w-1:0]        r_div_cnt;
    logic [c_bit_w-1:0]        r_bit_cnt;
    logic [1:0][DATA_BITS-1:0] r_in_reg;
    logic [1:0][DATA_BITS-1:0] r_frame_reg;
    logic                      r_in_full;

    logic                      w_active;
    logic                      w_div_wrap;
    logic                      w_load;
    logic                      w_frame_end;
    logic                      w_right;
    logic [1:0][DATA_BITS-1:0] w_frame;
    logic [c_bit_w-1:0]        w_slot_bit;
    logic [DATA_BITS-1:0]      w_chan;
    logic [DATA_BITS-1:0]      w_chan_shifted;
    logic                      w_sdo;

    always_comb begin
        w_active    = (r_state == c_run) || (r_state == c_stopping);
        w_div_wrap  = (r_div_cnt == c_div_last);
        w_load      = w_active && (r_div_cnt == '0) && (r_bit_cnt == '0);
        w_frame_end = w_div_wrap && (r_bit_cnt == c_bit_last);
        // The load cycle already emits bit 0, so it must see the data being loaded.
        w_frame = r_frame_reg;
        if (w_load) begin
            w_frame = r_in_full ? r_in_reg : '0;
        end
        w_right        = (r_bit_cnt >= c_slot);
        w_slot_bit     = w_right ? (r_bit_cnt - c_slot) : r_bit_cnt;
        w_chan         = w_right ? w_frame[1] : w_frame[0];
        w_chan_shifted = w_chan << w_slot_bit;
        w_sdo          = (w_slot_bit < c_data) && w_chan_shifted[DATA_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_in_reg     <= '0;
            r_frame_reg  <= '0;
            r_in_full    <= 1'b0;
            req_out      <= 1'b0;
            sck_out      <= 1'b0;
            ws_out       <= 1'b0;
            sdo_out      <= 1'b0;
            underrun_out <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            req_out      <= w_load;
            underrun_out <= w_load && !r_in_full;
            // A strobe coinciding with a load refills a buffer that is being emptied.
            overrun_out  <= valid_in && r_in_full && !w_load;

            if (w_load) begin
                r_frame_reg <= w_frame;
                r_in_full   <= 1'b0;
            end
            if (valid_in) begin
                r_in_reg  <= audio_in;
                r_in_full <= 1'b1;
            end

            if (w_active) begin
                sck_out   <= (r_div_cnt >= c_div_half);
                ws_out    <= (r_bit_cnt >= c_ws_first) && (r_bit_cnt <= c_ws_last);
                sdo_out   <= w_sdo;
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
                if (w_div_wrap) begin
                    r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
                end
            end else begin
                sck_out   <= 1'b0;
                ws_out    <= 1'b0;
                sdo_out   <= 1'b0;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
            end

            case (r_state)
                c_idle: begin
                    if (play_in) r_state <= c_run;
                end
                c_run: begin
                    if (!play_in) r_state <= c_stopping;
                end
                c_stopping: begin
                    if (play_in)          r_state <= c_run;
                    else if (w_frame_end) r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_unit
// Description : Self-checking bench for i2s_tx_unit: frame-level reference
//               model, I2S receiver, vector table and directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_unit;

    localparam int FRAME = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            play_in;
    logic            valid_in;
    logic [1:0][23:0] audio_in;
    logic            req_out, sck_out, ws_out, sdo_out, underrun_out, overrun_out;

    always #5 clk = ~clk;

    i2s_tx_unit #(.SCK_DIV(4), .DATA_BITS(24), .SLOT_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .play_in(play_in), .audio_in(audio_in),
        .valid_in(valid_in), .req_out(req_out), .sck_out(sck_out), .ws_out(ws_out),
        .sdo_out(sdo_out), .underrun_out(underrun_out), .overrun_out(overrun_out)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: frames of FRAME cycles, one-deep buffer, frames as {L,R}.
    bit          m_run = 0, m_prev_play = 0, m_full = 0;
    int          m_pos = 0;
    logic [47:0] m_buf = '0;
    logic [47:0] exp_q[$];
    logic [47:0] dec_q[$];
    bit          e_req = 0, e_under = 0, e_over = 0, e_idle = 1, e_sck = 0, e_ws = 0;

    // I2S receiver state
    bit          rx_on = 0;
    int          rx_n  = 0;
    logic [63:0] rx_data = '0, rx_ws = '0;
    logic        p_sck = 1'b0, p_sdo = 1'b0;

    task automatic model_step();
        bit load;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_full = 0; m_buf = '0; m_prev_play = 0;
            e_req = 0; e_under = 0; e_over = 0; e_idle = 1;
            exp_q.delete();
            rx_on = 0;
        end else begin
            load    = m_run && (m_pos == 0);
            e_req   = load;
            e_under = load && !m_full;
            e_over  = valid_in && m_full && !load;
            e_idle  = !m_run;
            e_sck   = (m_pos % 4) >= 2;
            e_ws    = (m_pos / 4 >= 31) && (m_pos / 4 <= 62);
            if (load) begin
                exp_q.push_back(m_full ? m_buf : 48'h0);
                m_full = 0;
            end
            if (valid_in) begin
                m_buf  = {audio_in[0], audio_in[1]};
                m_full = 1;
            end
            // Playback ends only if play was low for the last two cycles of a frame.
            if (!m_run) begin
                if (play_in) begin m_run = 1; m_pos = 0; end
            end else if (m_pos == FRAME - 1 && !play_in && !m_prev_play) begin
                m_run = 0; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            m_prev_play = play_in;
        end
    endtask

    task automatic monitor();
        logic [47:0] e;
        chk("pulses", 64'({req_out, underrun_out, overrun_out}), 64'({e_req, e_under, e_over}));
        if (e_idle) chk("idle_bus", 64'({sck_out, ws_out, sdo_out}), 64'(0));
        else        chk("sck_ws", 64'({sck_out, ws_out}), 64'({e_sck, e_ws}));
        if (sck_out && p_sck) chk("sdo_stable", 64'(sdo_out), 64'(p_sdo));
        if (req_out) begin rx_on = 1; rx_n = 0; end
        if (rx_on && sck_out && !p_sck) begin
            rx_data = {rx_data[62:0], sdo_out};
            rx_ws   = {rx_ws[62:0], ws_out};
            rx_n++;
            if (rx_n == 64) begin
                rx_on = 0;
                chk("ws_pattern", rx_ws, 64'h0000_0001_FFFF_FFFE);
                dec_q.push_back({rx_data[63:40], rx_data[31:8]});
                chk("frame_queue_depth", 64'(exp_q.size()), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("frame_stream", rx_data, {e[47:24], 8'h00, e[23:0], 8'h00});
                end
            end
        end
        p_sck = sck_out;
        p_sdo = sdo_out;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        monitor();
    endtask

    task automatic wait_req(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (req_out) seen = 1;
        end
    endtask

    task automatic wait_dec(input int n, input int budget, output bit ok);
        ok = (dec_q.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (dec_q.size() >= n);
        end
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        valid_in    = 1'b1;
        audio_in[0] = l;
        audio_in[1] = r;
        tick();
        valid_in    = 1'b0;
    endtask

    typedef struct {
        logic [23:0] l1, r1, l2, r2;
        int          nval;
        logic [23:0] exp_l, exp_r;
        bit          exp_under;
        int          exp_over;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit     seen, ok;
        int     n_over, n_req;
        longint t0;

        vecs[0] = '{24'hA5F00F, 24'h123456, 24'h0, 24'h0, 1, 24'hA5F00F, 24'h123456, 1'b0, 0};
        vecs[1] = '{24'h0, 24'h0, 24'h0, 24'h0, 0, 24'h000000, 24'h000000, 1'b1, 0};
        vecs[2] = '{24'h000001, 24'h00ABCD, 24'h000002, 24'h00BEEF, 2, 24'h000002, 24'h00BEEF, 1'b0, 1};
        vecs[3] = '{24'h800000, 24'h7FFFFF, 24'h0, 24'h0, 1, 24'h800000, 24'h7FFFFF, 1'b0, 0};
        vecs[4] = '{24'hFFFFFF, 24'h000001, 24'h0, 24'h0, 1, 24'hFFFFFF, 24'h000001, 1'b0, 0};

        rst_n = 1'b0; play_in = 1'b0; valid_in = 1'b0; audio_in = '0;
        repeat (3) tick();
        chk("reset_outputs", 64'({req_out, sck_out, ws_out, sdo_out, underrun_out, overrun_out}), 64'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Vector table: load buffer while idle, play exactly one frame, stop.
        for (int v = 0; v < 5; v++) begin
            n_over = 0;
            dec_q.delete();
            if (vecs[v].nval > 0) begin
                strobe(vecs[v].l1, vecs[v].r1);
                n_over += int'(overrun_out);
                tick();
            end
            if (vecs[v].nval > 1) begin
                strobe(vecs[v].l2, vecs[v].r2);
                n_over += int'(overrun_out);
                tick();
            end
            play_in = 1'b1;
            wait_req(8, seen);
            chk($sformatf("vec%0d_req_seen", v), 64'(seen), 64'(1));
            chk($sformatf("vec%0d_underrun", v), 64'(underrun_out), 64'(vecs[v].exp_under));
            play_in = 1'b0;
            wait_dec(1, 400, ok);
            chk($sformatf("vec%0d_frame_done", v), 64'(ok), 64'(1));
            if (ok) chk($sformatf("vec%0d_frame", v), 64'(dec_q[0]), 64'({vecs[v].exp_l, vecs[v].exp_r}));
            chk($sformatf("vec%0d_overruns", v), 64'(n_over), 64'(vecs[v].exp_over));
            repeat (8) tick();
        end

        // Strobe in the load cycle with an empty buffer; also req period.
        dec_q.delete();
        play_in = 1'b1;
        tick();
        valid_in = 1'b1; audio_in[0] = 24'h7FFFFF; audio_in[1] = 24'h000000;
        tick();
        valid_in = 1'b0;
        chk("simul_req", 64'(req_out), 64'(1));
        chk("simul_underrun", 64'(underrun_out), 64'(1));
        chk("simul_overrun", 64'(overrun_out), 64'(0));
        t0 = cyc;
        wait_req(300, seen);
        chk("period_req_seen", 64'(seen), 64'(1));
        chk("req_period", 64'(cyc - t0), 64'(256));
        chk("simul_next_underrun", 64'(underrun_out), 64'(0));
        wait_dec(2, 300, ok);
        chk("simul_frames_done", 64'(ok), 64'(1));
        if (ok) begin
            chk("simul_frame0", 64'(dec_q[0]), 64'(0));
            chk("simul_frame1", 64'(dec_q[1]), 64'({24'h7FFFFF, 24'h000000}));
        end

        // Stop request at bit 10: frame completes, then silence until play again.
        wait_req(10, seen);
        chk("stop_load_seen", 64'(seen), 64'(1));
        repeat (39) tick();
        play_in = 1'b0;
        n_req = 0;
        repeat (400) begin
            tick();
            n_req += int'(req_out);
        end
        chk("stop_no_req", 64'(n_req), 64'(0));
        chk("stop_frame_completed", 64'(dec_q.size()), 64'(3));
        chk("stop_idle_bus", 64'({sck_out, ws_out, sdo_out}), 64'(0));
        play_in = 1'b1;
        wait_req(4, seen);
        chk("restart_req", 64'(seen), 64'(1));
        chk("restart_underrun", 64'(underrun_out), 64'(1));

        // Mid-frame reset with a full buffer: the buffer must be discarded.
        strobe(24'h55AA55, 24'h0F0F0F);
        repeat (60) tick();
        rst_n = 1'b0; play_in = 1'b0;
        tick();
        chk("midrst_outputs", 64'({req_out, sck_out, ws_out, sdo_out, underrun_out, overrun_out}), 64'(0));
        rst_n = 1'b1;
        repeat (2) tick();
        play_in = 1'b1;
        wait_req(4, seen);
        chk("midrst_restart_req", 64'(seen), 64'(1));
        chk("midrst_buffer_cleared", 64'(underrun_out), 64'(1));
        play_in = 1'b0;
        repeat (300) tick();

        // Random traffic against the reference model.
        play_in = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            valid_in    = ($urandom_range(0, 119) == 0);
            audio_in[0] = 24'($urandom);
            audio_in[1] = 24'($urandom);
            if ($urandom_range(0, 699) == 0) play_in = ~play_in;
            tick();
        end
        valid_in = 1'b0;
        play_in  = 1'b0;
        repeat (600) tick();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
